bproc_rnea_sched: RTL and testbench

Backward-pass sequencer for the per-link RNEA force-propagation datapath. It holds per-link sin/cos and force vectors in a local bank and walks links NUM_LINKS down to 1. For each link it drives the combinational datapath, captures tau and the updated parent force, and writes the update back to the bank. It sits between the bproc load/unload logic and one shared datapath instance.

---
 rtl/bproc_rnea_sched_if.sv | 33 +++
 rtl/bproc_rnea_sched.sv | 232 +++++++++++++++++++++++
 tb/tb_bproc_rnea_sched.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bproc_rnea_sched_if.sv
// Bus between the RNEA backward-pass scheduler (master) and the shared
// per-link force-propagation datapath (slave).
interface bproc_rnea_sched_if #(
  parameter int WIDTH = 32
);
  logic [2:0]         dp_link_out;
  logic [WIDTH-1:0]   dp_sinq_out;
  logic [WIDTH-1:0]   dp_cosq_out;
  logic [6*WIDTH-1:0] dp_f_curr_vec_out;
  logic [6*WIDTH-1:0] dp_f_prev_vec_out;
  logic [WIDTH-1:0]   dp_tau_in;
  logic [6*WIDTH-1:0] dp_f_prev_upd_vec_in;

  modport master (
    output dp_link_out,
    output dp_sinq_out,
    output dp_cosq_out,
    output dp_f_curr_vec_out,
    output dp_f_prev_vec_out,
    input  dp_tau_in,
    input  dp_f_prev_upd_vec_in
  );

  modport slave (
    input  dp_link_out,
    input  dp_sinq_out,
    input  dp_cosq_out,
    input  dp_f_curr_vec_out,
    input  dp_f_prev_vec_out,
    output dp_tau_in,
    output dp_f_prev_upd_vec_in
  );
endinterface

// File: rtl/bproc_rnea_sched.sv
// RNEA backward-pass sequencer: walks links NUM_LINKS..1 through one shared datapath.
// Define BPROC_FWD_EN to forward the updated parent force straight into the next issue.
module bproc_rnea_sched #(
  parameter int WIDTH        = 32,
  parameter int DECIMAL_BITS = 16,
  parameter int NUM_LINKS    = 7,
  parameter int DP_WAIT      = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_in,
  input  logic               wr_en_in,
  input  logic [2:0]         wr_link_in,
  input  logic [WIDTH-1:0]   wr_sinq_in,
  input  logic [WIDTH-1:0]   wr_cosq_in,
  input  logic [6*WIDTH-1:0] wr_f_vec_in,
  output logic               busy_out,
  output logic               done_out,
  output logic               tau_valid_out,
  output logic [2:0]         tau_link_out,
  output logic [WIDTH-1:0]   tau_out,
  output logic [6*WIDTH-1:0] f_base_vec_out,
  bproc_rnea_sched_if.master dp
);

  localparam int               CNT_W      = (DP_WAIT > 1) ? $clog2(DP_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DP_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [2:0]       LAST_LINK  = 3'(NUM_LINKS);

  // The fraction width only describes the words flowing through; nothing here depends on it.
  if (DECIMAL_BITS >= WIDTH) begin : g_decimal_bits_not_below_width
  end

`ifdef BPROC_FWD_EN
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, RELOAD, DONE} state_t;
`endif

  state_t state_q;
  state_t state_d;

  logic [2:0]       k_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0]   sinq_bank [0:NUM_LINKS];
  logic [WIDTH-1:0]   cosq_bank [0:NUM_LINKS];
  logic [6*WIDTH-1:0] f_bank    [0:NUM_LINKS];

  logic [2:0]         link_q;
  logic [WIDTH-1:0]   sinq_q;
  logic [WIDTH-1:0]   cosq_q;
  logic [6*WIDTH-1:0] f_curr_q;
  logic [6*WIDTH-1:0] f_prev_q;
  logic               busy_q;
  logic               done_q;
  logic               tau_valid_q;
  logic [2:0]         tau_link_q;
  logic [WIDTH-1:0]   tau_q;

  logic       cnt_zero;
  logic       last_link;
  logic       start_load;
  logic       capture;
  logic       load_en;
  logic [2:0] load_idx;
  logic [2:0] load_prev_idx;
  logic [2:0] k_prev;
  logic       bank_wr;

  assign cnt_zero      = (cnt_q == '0);
  assign last_link     = (k_q == 3'd1);
  assign k_prev        = k_q - 3'd1;
  assign load_prev_idx = load_idx - 3'd1;
  assign bank_wr       = wr_en_in && !busy_q && (wr_link_in <= LAST_LINK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_zero) begin
          if (last_link) begin
            state_d = DONE;
          end
`ifndef BPROC_FWD_EN
          else begin
            state_d = RELOAD;
          end
`endif
        end
      end
`ifndef BPROC_FWD_EN
      RELOAD: state_d = ISSUE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decodes which edge loads the dp registers and from which bank entry.
  always_comb begin
    start_load = 1'b0;
    capture    = 1'b0;
    load_en    = 1'b0;
    load_idx   = LAST_LINK;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          start_load = 1'b1;
          load_en    = 1'b1;
          load_idx   = LAST_LINK;
        end
      end
      ISSUE: begin
        if (cnt_zero) begin
          capture = 1'b1;
`ifdef BPROC_FWD_EN
          if (!last_link) begin
            load_en  = 1'b1;
            load_idx = k_prev;
          end
`endif
        end
      end
`ifndef BPROC_FWD_EN
      RELOAD: begin
        load_en  = 1'b1;
        load_idx = k_q;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= NUM_LINKS; i++) begin
        sinq_bank[i] <= '0;
        cosq_bank[i] <= '0;
        f_bank[i]    <= '0;
      end
    end else begin
      if (bank_wr) begin
        sinq_bank[wr_link_in] <= wr_sinq_in;
        cosq_bank[wr_link_in] <= wr_cosq_in;
        f_bank[wr_link_in]    <= wr_f_vec_in;
      end
      if (capture) begin
        f_bank[k_prev] <= dp.dp_f_prev_upd_vec_in;
      end
    end
  end

  // Sequencing registers plus every registered output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_q         <= '0;
      cnt_q       <= '0;
      link_q      <= '0;
      sinq_q      <= '0;
      cosq_q      <= '0;
      f_curr_q    <= '0;
      f_prev_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tau_valid_q <= 1'b0;
      tau_link_q  <= '0;
      tau_q       <= '0;
    end else begin
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_q == DONE);
      tau_valid_q <= capture;

      if (start_load) begin
        k_q <= LAST_LINK;
      end else if (capture && !last_link) begin
        k_q <= k_prev;
      end

      if (load_en) begin
        cnt_q <= CNT_RELOAD;
      end else if ((state_q == ISSUE) && !cnt_zero) begin
        cnt_q <= cnt_q - CNT_ONE;
      end

      if (capture) begin
        tau_q      <= dp.dp_tau_in;
        tau_link_q <= k_q;
      end

      if (load_en) begin
        link_q   <= load_idx;
        sinq_q   <= sinq_bank[load_idx];
        cosq_q   <= cosq_bank[load_idx];
        f_prev_q <= f_bank[load_prev_idx];
`ifdef BPROC_FWD_EN
        // The bank write of this same edge is not visible yet, so take the datapath result.
        f_curr_q <= capture ? dp.dp_f_prev_upd_vec_in : f_bank[load_idx];
`else
        f_curr_q <= f_bank[load_idx];
`endif
      end
    end
  end

  assign busy_out             = busy_q;
  assign done_out             = done_q;
  assign tau_valid_out        = tau_valid_q;
  assign tau_link_out         = tau_link_q;
  assign tau_out              = tau_q;
  assign f_base_vec_out       = f_bank[0];
  assign dp.dp_link_out       = link_q;
  assign dp.dp_sinq_out       = sinq_q;
  assign dp.dp_cosq_out       = cosq_q;
  assign dp.dp_f_curr_vec_out = f_curr_q;
  assign dp.dp_f_prev_vec_out = f_prev_q;

endmodule

// File: tb/tb_bproc_rnea_sched.sv
// Scoreboard bench for bproc_rnea_sched with a stub datapath and a link-level reference model.
`timescale 1ns/1ps
module tb_bproc_rnea_sched;
  localparam int WIDTH     = 32;
  localparam int NUM_LINKS = 7;
  localparam int DP_WAIT   = 2;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start_in;
  logic               wr_en_in;
  logic [2:0]         wr_link_in;
  logic [WIDTH-1:0]   wr_sinq_in;
  logic [WIDTH-1:0]   wr_cosq_in;
  logic [6*WIDTH-1:0] wr_f_vec_in;
  logic               busy_out;
  logic               done_out;
  logic               tau_valid_out;
  logic [2:0]         tau_link_out;
  logic [WIDTH-1:0]   tau_out;
  logic [6*WIDTH-1:0] f_base_vec_out;

  bproc_rnea_sched_if #(.WIDTH(WIDTH)) dp_bus ();

  bproc_rnea_sched #(
    .WIDTH(WIDTH), .DECIMAL_BITS(16), .NUM_LINKS(NUM_LINKS), .DP_WAIT(DP_WAIT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_in(start_in),
    .wr_en_in(wr_en_in), .wr_link_in(wr_link_in), .wr_sinq_in(wr_sinq_in),
    .wr_cosq_in(wr_cosq_in), .wr_f_vec_in(wr_f_vec_in),
    .busy_out(busy_out), .done_out(done_out), .tau_valid_out(tau_valid_out),
    .tau_link_out(tau_link_out), .tau_out(tau_out), .f_base_vec_out(f_base_vec_out),
    .dp(dp_bus)
  );

  always #5 clk = ~clk;

  // Stub datapath: tau mixes f_curr.AZ with sin/cos so routing errors show up; parent force is f_prev+f_curr.
  always_comb begin
    dp_bus.dp_tau_in = dp_bus.dp_f_curr_vec_out[2*WIDTH +: WIDTH] + dp_bus.dp_sinq_out
                       + (dp_bus.dp_cosq_out << 1);
    dp_bus.dp_f_prev_upd_vec_in = '0;
    for (int w = 0; w < 6; w++) begin
      dp_bus.dp_f_prev_upd_vec_in[w*WIDTH +: WIDTH] = dp_bus.dp_f_prev_vec_out[w*WIDTH +: WIDTH]
                                                     + dp_bus.dp_f_curr_vec_out[w*WIDTH +: WIDTH];
    end
  end

  typedef struct {
    logic [2:0]       link;
    logic [WIDTH-1:0] tau;
    int               cyc;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [2:0] prev_link = '0;

  logic [WIDTH-1:0] m_sin [0:NUM_LINKS];
  logic [WIDTH-1:0] m_cos [0:NUM_LINKS];
  logic [WIDTH-1:0] m_f   [0:NUM_LINKS][0:5];
  logic [WIDTH-1:0] spec_tau [0:6] = '{32'h00070000, 32'h000D0000, 32'h00120000, 32'h00160000,
                                       32'h00190000, 32'h001B0000, 32'h001C0000};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [191:0] actual,
                              input logic [191:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a tau or a done pulse.
  always @(negedge clk) begin
    exp_t e;
    int   dc;
    if (!reset_n) begin
      prev_link = '0;
    end else begin
      if (tau_valid_out) begin
        if (exp_q.size() == 0) begin
          check_output("tau_unexpected", 192'(tau_link_out), 192'(0));
        end else begin
          e = exp_q.pop_front();
          check_output("tau", 192'(tau_out), 192'(e.tau));
          check_output("tau_link", 192'(tau_link_out), 192'(e.link));
          check_output("tau_cycle", 192'(cyc), 192'(e.cyc));
          check_output("dp_link", 192'(prev_link), 192'(e.link));
        end
      end
      if (done_out) begin
        if (done_q.size() == 0) begin
          check_output("done_unexpected", 192'(1), 192'(0));
        end else begin
          dc = done_q.pop_front();
          check_output("done_cycle", 192'(cyc), 192'(dc));
          check_output("busy_at_done", 192'(busy_out), 192'(0));
        end
      end
      prev_link = dp_bus.dp_link_out;
    end
  end

  function automatic int capture_offset(input int j);
`ifdef BPROC_FWD_EN
    return (j + 1) * DP_WAIT;
`else
    return (j + 1) * DP_WAIT + j;
`endif
  endfunction

  function automatic logic [6*WIDTH-1:0] model_f_packed(input int idx);
    logic [6*WIDTH-1:0] v;
    for (int w = 0; w < 6; w++) v[w*WIDTH +: WIDTH] = m_f[idx][w];
    return v;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k <= NUM_LINKS; k++) begin
      m_sin[k] = '0;
      m_cos[k] = '0;
      for (int w = 0; w < 6; w++) m_f[k][w] = '0;
    end
  endfunction

  // Reference: each link yields tau from its own entry, then adds its force into its parent.
  function automatic void model_pass(input bit use_spec, input int e0);
    exp_t e;
    int   last_cyc;
    last_cyc = e0;
    for (int k = NUM_LINKS; k >= 1; k--) begin
      e.link = 3'(k);
      e.tau  = use_spec ? spec_tau[NUM_LINKS-k] : (m_f[k][2] + m_sin[k] + (m_cos[k] << 1));
      e.cyc  = e0 + capture_offset(NUM_LINKS - k);
      last_cyc = e.cyc;
      exp_q.push_back(e);
      for (int w = 0; w < 6; w++) m_f[k-1][w] = m_f[k-1][w] + m_f[k][w];
    end
    done_q.push_back(last_cyc + 1);
  endfunction

  task automatic apply_write(input logic [2:0] link, input logic [WIDTH-1:0] s,
                             input logic [WIDTH-1:0] c, input logic [6*WIDTH-1:0] f);
    @(negedge clk);
    wr_en_in    = 1'b1;
    wr_link_in  = link;
    wr_sinq_in  = s;
    wr_cosq_in  = c;
    wr_f_vec_in = f;
    m_sin[link] = s;
    m_cos[link] = c;
    for (int w = 0; w < 6; w++) m_f[link][w] = f[w*WIDTH +: WIDTH];
    @(negedge clk);
    wr_en_in = 1'b0;
  endtask

  task automatic wait_drained(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      check_output({tag, "_timeout"}, 192'(exp_q.size() + done_q.size()), 192'(0));
      exp_q.delete();
      done_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Starts a pass; optionally pokes start_in and a bank write while the pass is running.
  task automatic apply_stimulus(input bit use_spec, input bit disturb);
    @(negedge clk);
    start_in = 1'b1;
    model_pass(use_spec, cyc + 1);
    @(negedge clk);
    start_in = 1'b0;
    if (disturb) begin
      repeat (2) @(negedge clk);
      check_output("busy_mid_pass", 192'(busy_out), 192'(1));
      start_in    = 1'b1;
      wr_en_in    = 1'b1;
      wr_link_in  = 3'd3;
      wr_f_vec_in = '0;
      wr_f_vec_in[2*WIDTH +: WIDTH] = 32'h7FFF0000;
      @(negedge clk);
      start_in = 1'b0;
      wr_en_in = 1'b0;
    end
    wait_drained("pass");
    check_output("f_base", f_base_vec_out, model_f_packed(0));
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_busy"}, 192'(busy_out), 192'(0));
    check_output({tag, "_done"}, 192'(done_out), 192'(0));
    check_output({tag, "_tau_valid"}, 192'(tau_valid_out), 192'(0));
    check_output({tag, "_tau_link"}, 192'(tau_link_out), 192'(0));
    check_output({tag, "_tau"}, 192'(tau_out), 192'(0));
    check_output({tag, "_dp_link"}, 192'(dp_bus.dp_link_out), 192'(0));
    check_output({tag, "_dp_sinq"}, 192'(dp_bus.dp_sinq_out), 192'(0));
    check_output({tag, "_dp_cosq"}, 192'(dp_bus.dp_cosq_out), 192'(0));
    check_output({tag, "_dp_f_curr"}, dp_bus.dp_f_curr_vec_out, 192'(0));
    check_output({tag, "_dp_f_prev"}, dp_bus.dp_f_prev_vec_out, 192'(0));
    check_output({tag, "_f_base"}, f_base_vec_out, 192'(0));
  endtask

  initial begin
    logic [6*WIDTH-1:0] fv;
    int n;
    reset_n     = 1'b0;
    start_in    = 1'b0;
    wr_en_in    = 1'b0;
    wr_link_in  = '0;
    wr_sinq_in  = '0;
    wr_cosq_in  = '0;
    wr_f_vec_in = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check_all_zero("por");
    reset_n = 1'b1;

    $display("[TB] directed pass: f[k].AZ = k.0");
    for (int k = 0; k <= NUM_LINKS; k++) begin
      fv = '0;
      fv[2*WIDTH +: WIDTH] = WIDTH'(k) << 16;
      apply_write(3'(k), '0, '0, fv);
    end
    apply_stimulus(1'b1, 1'b0);
    check_output("f_base_az", 192'(f_base_vec_out[2*WIDTH +: WIDTH]), 192'(32'h001C0000));

    $display("[TB] randomized passes");
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k <= NUM_LINKS; k++) begin
        for (int w = 0; w < 6; w++) fv[w*WIDTH +: WIDTH] = $urandom;
        apply_write(3'(k), WIDTH'(k) << 12 ^ $urandom_range(0, 4095), $urandom, fv);
      end
      apply_stimulus(1'b0, 1'b0);
    end

    $display("[TB] start and bank write while busy");
    apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0);

    $display("[TB] reset after link 5 capture");
    @(negedge clk);
    start_in = 1'b1;
    model_pass(1'b0, cyc + 1);
    @(negedge clk);
    start_in = 1'b0;
    n = 0;
    while (!(tau_valid_out && tau_link_out == 3'd5) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output("link5_seen", 192'(tau_link_out), 192'(5));
    #1 reset_n = 1'b0;
    exp_q.delete();
    done_q.delete();
    model_clear();
    #1 check_all_zero("mid_reset");
    @(negedge clk);
    reset_n = 1'b1;
    apply_stimulus(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
